vga_vram_scanner: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_vram_scanner_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 68 ++++++
 rtl/vga_vram_scanner.sv | 145 ++++++++++++++
 tb/tb_vga_vram_scanner.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VRAM raster scanner.
// Defaults describe 640x480@60 from a 100 MHz clock with a 128x96 frame buffer.
package vga_pkg;

    localparam int ADDR_W = 14;
    localparam int CNT_W  = 10;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SCALE    = 5;
    localparam int DEF_FB_WIDTH = 128;

    function automatic int total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL      = total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL      = total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // True when lo <= cnt < hi.
    function automatic logic in_window(logic [CNT_W-1:0] cnt, int lo, int hi);
        return (int'(cnt) >= lo) && (int'(cnt) < hi);
    endfunction

endpackage

// File: rtl/vga_vram_scanner_if.sv
// VRAM read port and VGA connector signals of the raster scanner.
// master = scanner side, slave = VRAM/connector side.
interface vga_vram_scanner_if import vga_pkg::*; ();

    logic [ADDR_W-1:0] vram_addr;
    logic              vram_red;
    logic              vram_green;
    logic              vram_blue;
    logic              vga_hsync;
    logic              vga_vsync;
    logic [3:0]        vga_red;
    logic [3:0]        vga_green;
    logic [3:0]        vga_blue;

    modport master (
        output vram_addr, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
        input  vram_red, vram_green, vram_blue
    );

    modport slave (
        input  vram_addr, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
        output vram_red, vram_green, vram_blue
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider and h/v raster counters; exposes next counter values so
// the address logic can register the address of the pixel the counters move to.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick_o,
    output logic             out_stb_o,
    output logic [CNT_W-1:0] h_nxt_o,
    output logic [CNT_W-1:0] v_nxt_o,
    output logic             active_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             line_last;

    always_comb begin
        tick_o    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        // One clock after the tick the VRAM has registered the new address.
        out_stb_o = (div_cnt_q == DIV_W'(1));
        div_cnt_d = tick_o ? '0 : div_cnt_q + 1'b1;

        line_last = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        h_nxt_o   = line_last ? '0 : h_cnt_q + 1'b1;
        v_nxt_o   = v_cnt_q;
        if (line_last) begin
            v_nxt_o = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
        end
        h_cnt_d = tick_o ? h_nxt_o : h_cnt_q;
        v_cnt_d = tick_o ? v_nxt_o : v_cnt_q;

        active_o  = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
        hsync_n_o = !in_window(h_cnt_q, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
        vsync_n_o = !in_window(v_cnt_q, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

endmodule

// File: rtl/vga_vram_scanner.sv
// Raster scanner: walks the frame buffer with SCALE x SCALE pixel replication
// using counters only, and aligns VRAM colour with sync at the VGA outputs.
module vga_vram_scanner
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SCALE    = DEF_SCALE,
    parameter int FB_WIDTH = DEF_FB_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    vga_vram_scanner_if.master bus
);

    localparam int SUB_W = $clog2(SCALE);
    localparam int COL_W = $clog2(FB_WIDTH);

    logic             tick, out_stb, active, hsync_n, vsync_n;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             line_end, frame_start;

    logic [SUB_W-1:0]  col_sub_q, col_sub_d;
    logic [SUB_W-1:0]  row_sub_q, row_sub_d;
    logic [COL_W-1:0]  col_addr_q, col_addr_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d;
    logic [2:0]        vram_bits;
    logic [2:0][3:0]   colour_q, colour_d;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk      (clk),
        .reset    (reset),
        .tick_o   (tick),
        .out_stb_o(out_stb),
        .h_nxt_o  (h_nxt),
        .v_nxt_o  (v_nxt),
        .active_o (active),
        .hsync_n_o(hsync_n),
        .vsync_n_o(vsync_n)
    );

    always_comb begin
        col_sub_d   = col_sub_q;
        row_sub_d   = row_sub_q;
        col_addr_d  = col_addr_q;
        line_base_d = line_base_q;
        vram_addr_d = vram_addr_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        line_end    = (h_nxt == '0);
        frame_start = line_end && (v_nxt == '0);

        if (tick) begin
            if (frame_start) begin
                col_sub_d   = '0;
                col_addr_d  = '0;
                row_sub_d   = '0;
                line_base_d = '0;
            end else if (line_end) begin
                col_sub_d  = '0;
                col_addr_d = '0;
                // Rows stop advancing after the last visible line so the base never passes the buffer.
                if (v_nxt < CNT_W'(V_ACTIVE)) begin
                    if (row_sub_q == SUB_W'(SCALE - 1)) begin
                        row_sub_d   = '0;
                        line_base_d = line_base_q + ADDR_W'(FB_WIDTH);
                    end else begin
                        row_sub_d = row_sub_q + 1'b1;
                    end
                end
            end else if (h_nxt < CNT_W'(H_ACTIVE)) begin
                if (col_sub_q == SUB_W'(SCALE - 1)) begin
                    col_sub_d  = '0;
                    col_addr_d = col_addr_q + 1'b1;
                end else begin
                    col_sub_d = col_sub_q + 1'b1;
                end
            end

            if (v_nxt >= CNT_W'(V_ACTIVE)) begin
                vram_addr_d = '0;
            end else if (h_nxt >= CNT_W'(H_ACTIVE)) begin
                vram_addr_d = line_base_d;
            end else begin
                vram_addr_d = line_base_d + ADDR_W'(col_addr_d);
            end
        end

        if (out_stb) begin
            hsync_d = hsync_n;
            vsync_d = vsync_n;
        end
    end

    assign vram_bits = {bus.vram_red, bus.vram_green, bus.vram_blue};

    // Blanking forces black regardless of what the VRAM returns.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_colour
            assign colour_d[gi] = out_stb ? (active ? {4{vram_bits[gi]}} : 4'h0) : colour_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            col_sub_q   <= '0;
            row_sub_q   <= '0;
            col_addr_q  <= '0;
            line_base_q <= '0;
            vram_addr_q <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            colour_q    <= '0;
        end else begin
            col_sub_q   <= col_sub_d;
            row_sub_q   <= row_sub_d;
            col_addr_q  <= col_addr_d;
            line_base_q <= line_base_d;
            vram_addr_q <= vram_addr_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            colour_q    <= colour_d;
        end
    end

    assign bus.vram_addr = vram_addr_q;
    assign bus.vga_hsync = hsync_q;
    assign bus.vga_vsync = vsync_q;
    assign bus.vga_red   = colour_q[2];
    assign bus.vga_green = colour_q[1];
    assign bus.vga_blue  = colour_q[0];

endmodule

// File: tb/tb_vga_vram_scanner.sv
// Scoreboard bench: a shrunken-timing scanner with random VRAM contents against
// an arithmetic raster model, plus a default-timing scanner probed at key pixels.
module tb_vga_vram_scanner;
    import vga_pkg::*;

    localparam int HA = 40, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
    localparam int SC = 5, FBW = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME_PIX = HT * VT;
    localparam int NPIX1 = 2 * FRAME_PIX + 20 * HT + 30;
    localparam int NPIX2 = FRAME_PIX + HT + 10;
    localparam logic [31:0] RST_OUT = 32'h0000_3000;

    typedef struct {
        int          t;
        bit          is_out;
        int          h;
        int          v;
        logic [31:0] exp;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tcyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [2:0] mem [64];
    logic [2:0] vram_q;
    sb_entry_t  sb_main[$];
    sb_entry_t  sb_dflt[$];

    vga_vram_scanner_if vif ();
    vga_vram_scanner_if vif0 ();

    vga_vram_scanner #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SCALE(SC), .FB_WIDTH(FBW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (vif.master)
    );

    vga_vram_scanner dut_dflt (
        .clk  (clk),
        .reset(reset),
        .bus  (vif0.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    // Synchronous-read VRAM for the small scanner; the default one sees blue only.
    always @(posedge clk) vram_q <= mem[vif.vram_addr[5:0]];
    assign vif.vram_red    = vram_q[2];
    assign vif.vram_green  = vram_q[1];
    assign vif.vram_blue   = vram_q[0];
    assign vif0.vram_red   = 1'b0;
    assign vif0.vram_green = 1'b0;
    assign vif0.vram_blue  = 1'b1;

    function automatic int model_addr(int h, int v);
        if (v >= VA) return 0;
        if (h >= HA) return (v / SC) * FBW;
        return (v / SC) * FBW + h / SC;
    endfunction

    function automatic logic [31:0] model_out(int h, int v);
        logic       act, hs, vs;
        logic [2:0] rgb;
        act = (h < HA) && (v < VA);
        hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
        vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
        rgb = act ? mem[model_addr(h, v)] : 3'b000;
        return {18'b0, hs, vs, {4{rgb[2]}}, {4{rgb[1]}}, {4{rgb[0]}}};
    endfunction

    task automatic check(input string name, input int h, input int v,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", name, h, v, act, exp);
        end
    endtask

    task automatic push(input bit dflt, input int t, input bit is_out, input int h,
                        input int v, input logic [31:0] exp);
        sb_entry_t e;
        e.t = t; e.is_out = is_out; e.h = h; e.v = v; e.exp = exp;
        if (dflt) sb_dflt.push_back(e);
        else      sb_main.push_back(e);
    endtask

    // Default-timing probe points (800-pixel lines), pushed in time order.
    task automatic pd(input int r, input bit is_out, input int k, input logic [31:0] exp);
        push(1, r + 4 * k + (is_out ? 2 : 0), is_out, k % 800, k / 800, exp);
    endtask

    task automatic push_dflt(input int r);
        pd(r, 1, 0, 32'h300F);
        pd(r, 0, 4, 0);
        pd(r, 0, 5, 1);
        pd(r, 0, 639, 127);
        pd(r, 1, 655, 32'h3000);
        pd(r, 1, 656, 32'h1000);
        pd(r, 1, 751, 32'h1000);
        pd(r, 1, 752, 32'h3000);
        pd(r, 0, 4 * 800 + 640, 0);
        pd(r, 0, 4 * 800 + 799, 0);
        pd(r, 0, 5 * 800, 128);
        pd(r, 0, 5 * 800 + 639, 255);
        pd(r, 1, 5 * 800 + 639, 32'h300F);
    endtask

    // Called on a falling edge: hold reset for ncyc rising edges, queue the
    // expected response from the reset state through npix pixels, then release.
    task automatic do_reset(input int ncyc, input int npix, input bit with_dflt);
        int r;
        reset = 1'b1;
        r = tcyc + ncyc;
        foreach (mem[i]) mem[i] = 3'($urandom);
        push(0, r, 1, -1, -1, RST_OUT);
        for (int k = 0; k <= npix; k++) begin
            int h, v;
            h = k % HT;
            v = (k / HT) % VT;
            push(0, r + 4 * k, 0, h, v, 32'(model_addr(h, v)));
            if (k < npix) push(0, r + 4 * k + 2, 1, h, v, model_out(h, v));
        end
        push(1, r, 0, -1, -1, 32'h0);
        push(1, r, 1, -1, -1, RST_OUT);
        if (with_dflt) push_dflt(r);
        repeat (ncyc) @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [31:0] a_addr, a_out, d_addr, d_out;
        a_addr = 32'(vif.vram_addr);
        a_out  = {18'b0, vif.vga_hsync, vif.vga_vsync, vif.vga_red, vif.vga_green, vif.vga_blue};
        d_addr = 32'(vif0.vram_addr);
        d_out  = {18'b0, vif0.vga_hsync, vif0.vga_vsync, vif0.vga_red, vif0.vga_green, vif0.vga_blue};
        while (sb_main.size() > 0 && sb_main[0].t <= tcyc) begin
            sb_entry_t e;
            e = sb_main.pop_front();
            if (e.t < tcyc) begin
                check("main_stale", e.h, e.v, 32'(tcyc), 32'(e.t));
            end else begin
                check(e.is_out ? "main_out" : "main_addr", e.h, e.v, e.is_out ? a_out : a_addr, e.exp);
                if (e.is_out && e.h == HT - 1)
                    $display("scan line v=%0d done: checks=%0d errors=%0d", e.v, n_checks, n_errors);
            end
        end
        while (sb_dflt.size() > 0 && sb_dflt[0].t <= tcyc) begin
            sb_entry_t e;
            e = sb_dflt.pop_front();
            if (e.t < tcyc) begin
                check("dflt_stale", e.h, e.v, 32'(tcyc), 32'(e.t));
            end else begin
                check(e.is_out ? "dflt_out" : "dflt_addr", e.h, e.v, e.is_out ? d_out : d_addr, e.exp);
                $display("default probe h=%0d v=%0d checked: errors=%0d", e.h, e.v, n_errors);
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset(3, NPIX1, 1'b1);
        // Counters now sit at (h=30, v=20) of the third frame; reset for one clock.
        repeat (4 * NPIX1) @(negedge clk);
        do_reset(1, NPIX2, 1'b0);
        for (int i = 0; i < 4 * NPIX2 + 64 && (sb_main.size() > 0 || sb_dflt.size() > 0); i++)
            @(negedge clk);
        if (sb_main.size() > 0 || sb_dflt.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries still pending, expected 0",
                     sb_main.size() + sb_dflt.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
